// File: rtl/dbg_sba_responder.sv
// dbg_sba_responder: memory-backed bus device answering the debug
// module's system-bus-access host port (req/gnt/r_valid protocol).
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   req_i                request valid, held by host until gnt_o
//   add_i, we_i          byte address, write enable
//   wdata_i, be_i        write data, byte enables
//   gnt_o                request accepted (single-cycle pulse)
//   r_valid_o            response valid (single-cycle pulse)
//   r_rdata_o            read data, zero outside r_valid_o
//   err_o, err_clr_i     sticky out-of-range flag and its clear
module dbg_sba_responder #(
    parameter int unsigned         BusWidth   = 32,
    parameter int unsigned         Depth      = 256,
    parameter logic [BusWidth-1:0] BaseAddr   = BusWidth'(32'h0010_0000),
    parameter int unsigned         GntDelay   = 0,
    parameter int unsigned         RspLatency = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [BusWidth-1:0]   add_i,
    input  logic                  we_i,
    input  logic [BusWidth-1:0]   wdata_i,
    input  logic [BusWidth/8-1:0] be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [BusWidth-1:0]   r_rdata_o,
    output logic                  err_o,
    input  logic                  err_clr_i
);

    localparam int unsigned Lanes    = BusWidth / 8;
    localparam int unsigned LaneBits = $clog2(Lanes);
    localparam int unsigned IdxBits  = $clog2(Depth);

    localparam logic [BusWidth-1:0] WinBytes = BusWidth'(Depth * Lanes);
    localparam logic [3:0] GntLoad = 4'((GntDelay == 0) ? 0 : GntDelay - 1);
    localparam logic [3:0] RspLoad = 4'(RspLatency - 1);

    if (BusWidth % 8 != 0 || BusWidth < 8) begin : g_bad_width
        $error("BusWidth must be a non-zero multiple of 8");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("Depth must be a power of two and at least 2");
    end
    if ((BaseAddr & (WinBytes - 1'b1)) != '0) begin : g_bad_base
        $error("BaseAddr must be aligned to the window size");
    end
    if (GntDelay > 15) begin : g_bad_gnt
        $error("GntDelay must be in 0..15");
    end
    if (RspLatency < 1 || RspLatency > 15) begin : g_bad_rsp
        $error("RspLatency must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                gnt, rsp;
    logic [BusWidth-1:0] off;
    logic                in_range;
    logic [IdxBits-1:0]  idx;
    logic [BusWidth-1:0] rdata_q;
    logic                err_q;
    logic [BusWidth-1:0] mem [Depth];

    // Wrapping subtraction makes addresses below the base land far out
    // of the window, so one compare covers both ends.
    assign off      = add_i - BaseAddr;
    assign in_range = off < WinBytes;
    assign idx      = off[LaneBits +: IdxBits];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        rsp     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (GntDelay == 0) begin
                        gnt     = 1'b1;
                        state_d = RESP;
                        cnt_d   = RspLoad;
                    end else begin
                        state_d = WAIT_GNT;
                        cnt_d   = GntLoad;
                    end
                end
            end
            WAIT_GNT: begin
                if (!req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    gnt     = 1'b1;
                    state_d = RESP;
                    cnt_d   = RspLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (cnt_q == '0) begin
                    rsp     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Read data is frozen at grant, so a later write cannot
            // disturb a response still counting down its latency.
            if (gnt) begin
                rdata_q <= (in_range && !we_i) ? mem[idx] : '0;
            end
            // A new error beats a simultaneous clear.
            if (gnt && !in_range) begin
                err_q <= 1'b1;
            end else if (err_clr_i) begin
                err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem[i] <= '0;
            end
        end else if (gnt && we_i && in_range) begin
            for (int k = 0; k < int'(Lanes); k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign gnt_o     = gnt;
    assign r_valid_o = rsp;
    assign r_rdata_o = rsp ? rdata_q : '0;
    assign err_o     = err_q;

    a_gnt_req : assert property (
        @(posedge clk_i) disable iff (!rst_ni) gnt_o |-> req_i);

    a_gnt_rsp : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(gnt_o && r_valid_o));

    a_gnt_pulse : assert property (
        @(posedge clk_i) disable iff (!rst_ni) gnt_o |=> !gnt_o);

    a_no_gnt_resp : assert property (
        @(posedge clk_i) disable iff (!rst_ni) (state_q == RESP) |-> !gnt_o);

endmodule

// File: tb/tb_dbg_sba_responder.sv
// tb_dbg_sba_responder: self-checking bench for dbg_sba_responder.
// Three instances: u_a (0/1), u_b (GntDelay 3, RspLatency 4), u_c (0/5).
module tb_dbg_sba_responder;

    typedef struct {
        logic [31:0] data;
        int          lat;
        bit          chk;
    } exp_t;

    localparam int GD [3] = '{0, 3, 0};
    localparam int RL [3] = '{1, 4, 5};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req     [3];
    logic        we      [3];
    logic        err_clr [3];
    logic [31:0] add     [3];
    logic [31:0] wdata   [3];
    logic [3:0]  be      [3];
    logic        gnt     [3];
    logic        rvalid  [3];
    logic        err     [3];
    logic [31:0] rdata   [3];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbg_sba_responder #(.GntDelay(0), .RspLatency(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .add_i(add[0]),
        .we_i(we[0]), .wdata_i(wdata[0]), .be_i(be[0]), .gnt_o(gnt[0]),
        .r_valid_o(rvalid[0]), .r_rdata_o(rdata[0]), .err_o(err[0]),
        .err_clr_i(err_clr[0])
    );

    dbg_sba_responder #(.GntDelay(3), .RspLatency(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .add_i(add[1]),
        .we_i(we[1]), .wdata_i(wdata[1]), .be_i(be[1]), .gnt_o(gnt[1]),
        .r_valid_o(rvalid[1]), .r_rdata_o(rdata[1]), .err_o(err[1]),
        .err_clr_i(err_clr[1])
    );

    dbg_sba_responder #(.GntDelay(0), .RspLatency(5)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .add_i(add[2]),
        .we_i(we[2]), .wdata_i(wdata[2]), .be_i(be[2]), .gnt_o(gnt[2]),
        .r_valid_o(rvalid[2]), .r_rdata_o(rdata[2]), .err_o(err[2]),
        .err_clr_i(err_clr[2])
    );

    task automatic txn(input string nm, input int u, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] rexp,
                       input bit hold, output int gcyc);
        int   k;
        int   lat;
        bit   extra;
        exp_t e;
        @(negedge clk);
        req[u] = 1'b1;
        we[u] = w;
        add[u] = a;
        wdata[u] = d;
        be[u] = b;
        #1;
        k = 0;
        while (gnt[u] !== 1'b1 && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        gcyc = cyc;
        checks++;
        if (gnt[u] !== 1'b1) begin
            errors++;
            $display("FAIL %s grant: none within %0d cycles", nm, k);
            req[u] = 1'b0;
            return;
        end
        checks++;
        if (k != GD[u]) begin
            errors++;
            $display("FAIL %s gnt_delay: got %0d expected %0d", nm, k, GD[u]);
        end
        e.data = rexp;
        e.lat = RL[u];
        e.chk = !w;
        sb_q.push_back(e);
        lat = 0;
        extra = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
            if (gnt[u] === 1'b1) extra = 1;
            if (!hold) req[u] = 1'b0;
        end while (rvalid[u] !== 1'b1 && lat < 40);
        e = sb_q.pop_front();
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL %s extra_gnt: got 1 expected 0", nm);
        end
        checks++;
        if (lat != e.lat) begin
            errors++;
            $display("FAIL %s rsp_latency: got %0d expected %0d", nm, lat, e.lat);
        end
        if (e.chk) begin
            checks++;
            if (rdata[u] !== e.data) begin
                errors++;
                $display("FAIL %s rdata: got %h expected %h", nm, rdata[u], e.data);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            checks++;
            if ({gnt[u], rvalid[u], err[u], rdata[u]} !== 35'b0) begin
                errors++;
                $display("FAIL reset_outs[%0d]: got %b%b%b_%h expected 0",
                         u, gnt[u], rvalid[u], err[u], rdata[u]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        int g;
        txn("def_wr", 0, 1, 32'h0010_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, g);
        txn("def_rd", 0, 0, 32'h0010_0004, 0, 4'hF, 32'hDEAD_BEEF, 0, g);
        @(negedge clk);
        #1;
        checks++;
        if (rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL rdata_idle: got %h expected 0", rdata[0]);
        end
        txn("unaligned_rd", 0, 0, 32'h0010_0006, 0, 4'h0, 32'hDEAD_BEEF, 0, g);
    endtask

    task automatic test_partial();
        int g;
        txn("pw_init", 0, 1, 32'h0010_0008, 32'hAABB_CCDD, 4'hF, 0, 0, g);
        txn("pw_wr", 0, 1, 32'h0010_0008, 32'h1122_3344, 4'b0101, 0, 0, g);
        txn("pw_rd", 0, 0, 32'h0010_0008, 0, 4'hF, 32'hAA22_CC44, 0, g);
        txn("be0_wr", 0, 1, 32'h0010_0008, 32'hFFFF_FFFF, 4'h0, 0, 0, g);
        txn("be0_rd", 0, 0, 32'h0010_0008, 0, 4'hF, 32'hAA22_CC44, 0, g);
    endtask

    task automatic test_delay();
        int g;
        txn("dly_wr", 1, 1, 32'h0010_0020, 32'h1234_5678, 4'hF, 0, 0, g);
        txn("dly_rd", 1, 0, 32'h0010_0020, 0, 4'hF, 32'h1234_5678, 0, g);
    endtask

    task automatic chk_err(input string nm, input logic exp);
        checks++;
        if (err[0] !== exp) begin
            errors++;
            $display("FAIL %s: err got %b expected %b", nm, err[0], exp);
        end
    endtask

    task automatic test_out_of_range();
        int g;
        chk_err("err_pre", 1'b0);
        txn("oor_wr", 0, 1, 32'h0010_0400, 32'h5555_5555, 4'hF, 0, 0, g);
        chk_err("err_oor_wr", 1'b1);
        txn("alias_rd", 0, 0, 32'h0010_0000, 0, 4'hF, 32'h0, 0, g);
        @(negedge clk);
        err_clr[0] = 1'b1;
        @(negedge clk);
        #1;
        err_clr[0] = 1'b0;
        chk_err("err_clr", 1'b0);
        txn("oor_rd", 0, 0, 32'h0010_0400, 0, 4'hF, 32'h0, 0, g);
        chk_err("err_oor_rd", 1'b1);
        @(negedge clk);
        err_clr[0] = 1'b1;
        @(negedge clk);
        #1;
        err_clr[0] = 1'b0;
        chk_err("err_clr2", 1'b0);
        err_clr[0] = 1'b1;
        txn("below_rd", 0, 0, 32'h000F_FFFC, 0, 4'hF, 32'h0, 0, g);
        err_clr[0] = 1'b0;
        chk_err("err_set_wins", 1'b1);
        @(negedge clk);
        #1;
        chk_err("err_sticky", 1'b1);
        err_clr[0] = 1'b1;
        @(negedge clk);
        #1;
        err_clr[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int          g;
        int          prev;
        logic [31:0] a;
        logic [31:0] d;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            a = 32'h0010_0010 + 32'(4 * i);
            d = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
            txn("b2b_wr", 0, 1, a, d, 4'hF, 0, i < 3, g);
            if (i > 0) begin
                checks++;
                if (g - prev != RL[0] + 1) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: got %0d expected %0d",
                             i, g - prev, RL[0] + 1);
                end
            end
            prev = g;
        end
        for (int i = 0; i < 4; i++) begin
            a = 32'h0010_0010 + 32'(4 * i);
            d = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
            txn("b2b_rd", 0, 0, a, 0, 4'hF, d, 0, g);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        bit seen;
        txn("rm_wr", 2, 1, 32'h0010_0040, 32'hCAFE_F00D, 4'hF, 0, 0, g);
        @(negedge clk);
        req[2] = 1'b1;
        we[2] = 1'b0;
        add[2] = 32'h0010_0040;
        be[2] = 4'hF;
        #1;
        checks++;
        if (gnt[2] !== 1'b1) begin
            errors++;
            $display("FAIL rm_gnt: got %b expected 1", gnt[2]);
        end
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (rvalid[2] === 1'b1) seen = 1;
            if (i == 2) rst_n = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rm_lost_rsp: r_valid got 1 expected 0");
        end
        txn("rm_rd_zero", 2, 0, 32'h0010_0040, 0, 4'hF, 32'h0, 0, g);
        txn("rm_wr2", 2, 1, 32'h0010_0044, 32'h0BAD_C0DE, 4'hF, 0, 0, g);
        txn("rm_rd2", 2, 0, 32'h0010_0044, 0, 4'hF, 32'h0BAD_C0DE, 0, g);
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            req[u] = 1'b0;
            we[u] = 1'b0;
            err_clr[u] = 1'b0;
            add[u] = '0;
            wdata[u] = '0;
            be[u] = '0;
        end
        test_reset();
        test_defaults();
        test_partial();
        test_delay();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
